top_counter: RTL and testbench

//   Demo counter subsystem with two 4-bit counters driven from refclk.
//   - count_up: free-running up counter.
//   - count_down: direction-controlled counter.
//   A lock emulator gates counting. It stands in for the PLL: a lock

---
 rtl/top_counter.sv | 85 ++++++++
 tb/tb_top_counter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/top_counter.sv
// top_counter: two registered counters gated by an emulated PLL lock.
// A lock counter raises an internal locked flag a fixed number of refclk
// edges after reset_pll is released; a prescaler then produces count ticks.
module top_counter #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned LOCK_CYCLES = 2,
  parameter int unsigned CLK_DIV     = 1
) (
  input  logic             refclk,
  input  logic             reset_pll,
  input  logic             reset_count,
  input  logic             counter_direction,
  output logic [WIDTH-1:0] count_up,
  output logic [WIDTH-1:0] count_down
);

  localparam int unsigned LW = $clog2(LOCK_CYCLES + 1);
  localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [LW-1:0] LOCK_LAST  = LW'(LOCK_CYCLES - 1);
  localparam logic [LW-1:0] LOCK_MAX   = LW'(LOCK_CYCLES);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

  logic [LW-1:0]    lock_cnt_q, lock_cnt_d;
  logic             locked_q, locked_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [WIDTH-1:0] up_q, up_d;
  logic [WIDTH-1:0] down_q, down_d;
  logic             run;
  logic             tick;

  // Next-state: reset priority, lock emulation, prescaler and counters
  always_comb begin
    lock_cnt_d = lock_cnt_q;
    locked_d   = locked_q;
    presc_d    = presc_q;
    up_d       = up_q;
    down_d     = down_q;
    run        = locked_q & ~reset_count;
    tick       = run & (presc_q == PRESC_LAST);

    if (reset_pll) begin
      lock_cnt_d = '0;
      locked_d   = 1'b0;
      presc_d    = '0;
      up_d       = '0;
      down_d     = '0;
      tick       = 1'b0;
    end else begin
      // The lock counter saturates at LOCK_CYCLES; locked rises on the
      // edge that takes it from LOCK_CYCLES-1 to LOCK_CYCLES.
      if (lock_cnt_q != LOCK_MAX) begin
        lock_cnt_d = lock_cnt_q + 1'b1;
      end
      if (lock_cnt_q == LOCK_LAST) begin
        locked_d = 1'b1;
      end

      if (reset_count) begin
        presc_d = '0;
        up_d    = '0;
        down_d  = '0;
      end else if (run) begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        if (tick) begin
          up_d   = up_q + 1'b1;
          down_d = counter_direction ? down_q + 1'b1 : down_q - 1'b1;
        end
      end
    end
  end

  // State registers; all resets are synchronous and handled in next-state logic
  always_ff @(posedge refclk) begin
    lock_cnt_q <= lock_cnt_d;
    locked_q   <= locked_d;
    presc_q    <= presc_d;
    up_q       <= up_d;
    down_q     <= down_d;
  end

  assign count_up   = up_q;
  assign count_down = down_q;

endmodule

// File: tb/tb_top_counter.sv
// tb_top_counter: scoreboard bench for top_counter at default parameters.
// Each driven edge pushes the expected counter pair; it is popped and
// compared one time unit after that edge.
module tb_top_counter;

  localparam int unsigned LOCK_CYCLES = 2;

  logic       refclk = 1'b0;
  logic       reset_pll;
  logic       reset_count;
  logic       counter_direction;
  logic [3:0] count_up;
  logic [3:0] count_down;

  typedef struct packed {
    logic [3:0] up;
    logic [3:0] dn;
  } exp_t;

  exp_t sb_q[$];
  exp_t exp_v;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference state of the expected behaviour
  int         m_lock = 0;
  bit         m_locked = 1'b0;
  logic [3:0] m_up = '0;
  logic [3:0] m_dn = '0;

  top_counter #(.WIDTH(4), .LOCK_CYCLES(LOCK_CYCLES), .CLK_DIV(1)) dut (
    .refclk           (refclk),
    .reset_pll        (reset_pll),
    .reset_count      (reset_count),
    .counter_direction(counter_direction),
    .count_up         (count_up),
    .count_down       (count_down)
  );

  always #10 refclk = ~refclk;

  // Drive one edge worth of inputs, push the expected result, advance past the edge
  task automatic drive_edge(input bit rp, input bit rc, input bit dir);
    reset_pll         = rp;
    reset_count       = rc;
    counter_direction = dir;
    if (rp) begin
      m_lock = 0; m_locked = 1'b0; m_up = '0; m_dn = '0;
    end else begin
      if (rc) begin
        m_up = '0; m_dn = '0;
      end else if (m_locked) begin
        m_up = m_up + 4'd1;
        m_dn = dir ? m_dn + 4'd1 : m_dn - 4'd1;
      end
      if (m_lock + 1 >= LOCK_CYCLES) m_locked = 1'b1;
      if (m_lock < LOCK_CYCLES) m_lock++;
    end
    sb_q.push_back('{up: m_up, dn: m_dn});
    @(posedge refclk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      drive_edge(i < 3, 1'b1, 1'b0);
      exp_v = sb_q.pop_front();
      n_cmp++;
      if (count_up !== exp_v.up || count_down !== exp_v.dn) begin
        n_bad++;
        $display("FAIL reset[%0d]: up=%h dn=%h, expected up=%h dn=%h", i, count_up, count_down, exp_v.up, exp_v.dn);
      end
    end
    n_cmp++;
    if (count_up !== 4'h0 || count_down !== 4'h0) begin
      n_bad++;
      $display("FAIL reset_final: up=%h dn=%h, expected up=0 dn=0", count_up, count_down);
    end
  endtask

  task automatic test_count_release();
    for (int i = 0; i < 8; i++) begin
      drive_edge(1'b0, i < 5, 1'b0);
      exp_v = sb_q.pop_front();
      n_cmp++;
      if (count_up !== exp_v.up || count_down !== exp_v.dn) begin
        n_bad++;
        $display("FAIL release[%0d]: up=%h dn=%h, expected up=%h dn=%h", i, count_up, count_down, exp_v.up, exp_v.dn);
      end
    end
    n_cmp++;
    if (count_up !== 4'h3 || count_down !== 4'hD) begin
      n_bad++;
      $display("FAIL release_3ticks: up=%h dn=%h, expected up=3 dn=D", count_up, count_down);
    end
  endtask

  task automatic test_wrap();
    drive_edge(1'b0, 1'b1, 1'b0);
    void'(sb_q.pop_front());
    for (int i = 0; i < 17; i++) begin
      drive_edge(1'b0, 1'b0, 1'b0);
      exp_v = sb_q.pop_front();
      n_cmp++;
      if (count_up !== exp_v.up || count_down !== exp_v.dn) begin
        n_bad++;
        $display("FAIL wrap[%0d]: up=%h dn=%h, expected up=%h dn=%h", i, count_up, count_down, exp_v.up, exp_v.dn);
      end
    end
    n_cmp++;
    if (count_up !== 4'h1 || count_down !== 4'hF) begin
      n_bad++;
      $display("FAIL wrap_17: up=%h dn=%h, expected up=1 dn=F", count_up, count_down);
    end
  endtask

  // up-down parity is invariant from reset, so start from 7/5 (reachable)
  task automatic test_direction();
    bit dirs[11] = '{1, 1, 1, 1, 1, 1, 0, 1, 1, 1, 0};
    drive_edge(1'b0, 1'b1, 1'b0);
    void'(sb_q.pop_front());
    for (int i = 0; i < 11; i++) begin
      drive_edge(1'b0, 1'b0, dirs[i]);
      exp_v = sb_q.pop_front();
      n_cmp++;
      if (count_up !== exp_v.up || count_down !== exp_v.dn) begin
        n_bad++;
        $display("FAIL dir[%0d]: up=%h dn=%h, expected up=%h dn=%h", i, count_up, count_down, exp_v.up, exp_v.dn);
      end
      if (i == 9) begin
        n_cmp++;
        if (count_up !== 4'hA || count_down !== 4'h8) begin
          n_bad++;
          $display("FAIL dir_up3: up=%h dn=%h, expected up=A dn=8", count_up, count_down);
        end
      end
    end
    n_cmp++;
    if (count_up !== 4'hB || count_down !== 4'h7) begin
      n_bad++;
      $display("FAIL dir_down1: up=%h dn=%h, expected up=B dn=7", count_up, count_down);
    end
  endtask

  task automatic test_back_to_back_count_reset();
    bit rcs[5] = '{0, 0, 1, 0, 0};
    for (int i = 0; i < 5; i++) begin
      drive_edge(1'b0, rcs[i], 1'b0);
      exp_v = sb_q.pop_front();
      n_cmp++;
      if (count_up !== exp_v.up || count_down !== exp_v.dn) begin
        n_bad++;
        $display("FAIL cnt_rst[%0d]: up=%h dn=%h, expected up=%h dn=%h", i, count_up, count_down, exp_v.up, exp_v.dn);
      end
      if (i == 3) begin
        n_cmp++;
        if (count_up !== 4'h1 || count_down !== 4'hF) begin
          n_bad++;
          $display("FAIL cnt_rst_resume: up=%h dn=%h, expected up=1 dn=F", count_up, count_down);
        end
      end
    end
  endtask

  // Pulses reset_pll (optionally with reset_count) and checks the fresh lock wait
  task automatic test_pll_reset(input bit with_rc);
    for (int i = 0; i < 6; i++) begin
      drive_edge(i == 1, (i == 1) && with_rc, 1'b1);
      exp_v = sb_q.pop_front();
      n_cmp++;
      if (count_up !== exp_v.up || count_down !== exp_v.dn) begin
        n_bad++;
        $display("FAIL pll_rst%0d[%0d]: up=%h dn=%h, expected up=%h dn=%h", with_rc, i, count_up, count_down, exp_v.up, exp_v.dn);
      end
      if (i == 3) begin
        n_cmp++;
        if (count_up !== 4'h0 || count_down !== 4'h0) begin
          n_bad++;
          $display("FAIL pll_rst%0d_wait: up=%h dn=%h, expected up=0 dn=0", with_rc, count_up, count_down);
        end
      end
      if (i == 4) begin
        n_cmp++;
        if (count_up !== 4'h1 || count_down !== 4'h1) begin
          n_bad++;
          $display("FAIL pll_rst%0d_resume: up=%h dn=%h, expected up=1 dn=1", with_rc, count_up, count_down);
        end
      end
    end
  endtask

  initial begin
    reset_pll         = 1'b1;
    reset_count       = 1'b1;
    counter_direction = 1'b0;
    @(negedge refclk);
    test_reset();
    test_count_release();
    test_wrap();
    test_direction();
    test_back_to_back_count_reset();
    test_pll_reset(1'b0);
    test_pll_reset(1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
